// File: rtl/mem_stage.sv
// RV64 memory-access stage: forwards ALU results to writeback and runs one
// aligned load/store transaction per memory op on the data-cache port.
module mem_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              dc_req_valid,
    input  logic              dc_req_ready,
    output logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_we,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [7:0]        dc_req_wstrb,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_data,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {K_NONE, K_LOAD, K_STORE} kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [1:0] lg_size;   // log2 of access size in bytes
        logic       sext;
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '{kind: K_NONE, lg_size: 2'd0, sext: 1'b0};
        case (op)
            4'd1:    d = '{kind: K_LOAD,  lg_size: 2'd0, sext: 1'b1};
            4'd2:    d = '{kind: K_LOAD,  lg_size: 2'd1, sext: 1'b1};
            4'd3:    d = '{kind: K_LOAD,  lg_size: 2'd2, sext: 1'b1};
            4'd4:    d = '{kind: K_LOAD,  lg_size: 2'd3, sext: 1'b1};
            4'd5:    d = '{kind: K_LOAD,  lg_size: 2'd0, sext: 1'b0};
            4'd6:    d = '{kind: K_LOAD,  lg_size: 2'd1, sext: 1'b0};
            4'd7:    d = '{kind: K_LOAD,  lg_size: 2'd2, sext: 1'b0};
            4'd8:    d = '{kind: K_STORE, lg_size: 2'd0, sext: 1'b0};
            4'd9:    d = '{kind: K_STORE, lg_size: 2'd1, sext: 1'b0};
            4'd10:   d = '{kind: K_STORE, lg_size: 2'd2, sext: 1'b0};
            4'd11:   d = '{kind: K_STORE, lg_size: 2'd3, sext: 1'b0};
            default: d = '{kind: K_NONE,  lg_size: 2'd0, sext: 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] lg);
        case (lg)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] data_mask(input logic [1:0] lg);
        case (lg)
            2'd0:    return {{(XLEN-8){1'b0}},  8'hFF};
            2'd1:    return {{(XLEN-16){1'b0}}, 16'hFFFF};
            2'd2:    return {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            default: return {XLEN{1'b1}};
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0] lg,
                                               input logic sext);
        case (lg)
            2'd0:    return {{(XLEN-8){sext & raw[7]}},   raw[7:0]};
            2'd1:    return {{(XLEN-16){sext & raw[15]}}, raw[15:0]};
            2'd2:    return {{(XLEN-32){sext & raw[31]}}, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        off_q, off_d;
    logic [1:0]        lg_q, lg_d;
    logic              sext_q, sext_d;
    logic              store_q, store_d;
    logic              dc_req_valid_q, dc_req_valid_d;
    logic [ADDR_W-1:0] dc_req_addr_q, dc_req_addr_d;
    logic              dc_req_we_q, dc_req_we_d;
    logic [XLEN-1:0]   dc_req_wdata_q, dc_req_wdata_d;
    logic [7:0]        dc_req_wstrb_q, dc_req_wstrb_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    dec_t              dec;
    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        acc_off;
    logic [2:0]        off_mask;
    logic              misaligned;
    logic              accept;
    logic              is_store;
    logic [XLEN-1:0]   resp_raw;

    // Loads carry their address on in_data; stores carry it on in_addr.
    assign dec        = decode(in_op);
    assign is_store   = (dec.kind == K_STORE);
    assign acc_addr   = is_store ? in_addr : ADDR_W'(in_data);
    assign acc_off    = acc_addr[2:0];
    assign off_mask   = 3'b111 >> (2'd3 - dec.lg_size);
    assign misaligned = (acc_off & off_mask) != 3'b000;
    assign accept     = in_valid && in_ready_q;
    assign resp_raw   = dc_resp_data >> {off_q, 3'b000};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        in_ready_d     = in_ready_q;
        rd_d           = rd_q;
        off_d          = off_q;
        lg_d           = lg_q;
        sext_d         = sext_q;
        store_d        = store_q;
        dc_req_valid_d = dc_req_valid_q;
        dc_req_addr_d  = dc_req_addr_q;
        dc_req_we_d    = dc_req_we_q;
        dc_req_wdata_d = dc_req_wdata_q;
        dc_req_wstrb_d = dc_req_wstrb_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        err_valid_d    = 1'b0;
        err_addr_d     = err_addr_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec.kind == K_NONE) begin
                        if (in_rd != 5'd0) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = in_rd;
                            wb_data_d  = in_data;
                        end
                    end else if (misaligned) begin
                        err_valid_d = 1'b1;
                        err_addr_d  = acc_addr;
                    end else begin
                        state_d        = REQ;
                        in_ready_d     = 1'b0;
                        rd_d           = in_rd;
                        off_d          = acc_off;
                        lg_d           = dec.lg_size;
                        sext_d         = dec.sext;
                        store_d        = is_store;
                        dc_req_valid_d = 1'b1;
                        dc_req_addr_d  = {acc_addr[ADDR_W-1:3], 3'b000};
                        dc_req_we_d    = is_store;
                        dc_req_wstrb_d = is_store ? (lane_mask(dec.lg_size) << acc_off) : 8'h00;
                        dc_req_wdata_d = is_store
                            ? ((in_data & data_mask(dec.lg_size)) << {acc_off, 3'b000})
                            : '0;
                    end
                end
            end
            REQ: begin
                if (dc_req_ready) begin
                    dc_req_valid_d = 1'b0;
                    dc_req_addr_d  = '0;
                    dc_req_we_d    = 1'b0;
                    dc_req_wdata_d = '0;
                    dc_req_wstrb_d = 8'h00;
                    state_d        = store_q ? IDLE : WAIT;
                    in_ready_d     = store_q;
                end
            end
            WAIT: begin
                if (dc_resp_valid) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                    if (rd_q != 5'd0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = extend(resp_raw, lg_q, sext_q);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b1;
            rd_q           <= '0;
            off_q          <= '0;
            lg_q           <= '0;
            sext_q         <= 1'b0;
            store_q        <= 1'b0;
            dc_req_valid_q <= 1'b0;
            dc_req_addr_q  <= '0;
            dc_req_we_q    <= 1'b0;
            dc_req_wdata_q <= '0;
            dc_req_wstrb_q <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            err_valid_q    <= 1'b0;
            err_addr_q     <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the values
            // from before this edge regardless of statement order.
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            rd_q           <= rd_d;
            off_q          <= off_d;
            lg_q           <= lg_d;
            sext_q         <= sext_d;
            store_q        <= store_d;
            dc_req_valid_q <= dc_req_valid_d;
            dc_req_addr_q  <= dc_req_addr_d;
            dc_req_we_q    <= dc_req_we_d;
            dc_req_wdata_q <= dc_req_wdata_d;
            dc_req_wstrb_q <= dc_req_wstrb_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            err_valid_q    <= err_valid_d;
            err_addr_q     <= err_addr_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign dc_req_valid = dc_req_valid_q;
    assign dc_req_addr  = dc_req_addr_q;
    assign dc_req_we    = dc_req_we_q;
    assign dc_req_wdata = dc_req_wdata_q;
    assign dc_req_wstrb = dc_req_wstrb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign err_valid    = err_valid_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-level memory reference model, a behavioural data
// cache, and a queue scoreboard checked by a monitor on the falling edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [63:0] in_data, in_addr;
    logic        dc_req_valid, dc_req_ready, dc_req_we;
    logic [63:0] dc_req_addr, dc_req_wdata;
    logic [7:0]  dc_req_wstrb;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_data;
    logic        wb_valid, err_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, err_addr;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_data(in_data), .in_addr(in_addr),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
        .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    typedef struct { logic [4:0] rd; logic [63:0] data; int cyc; } wb_exp_t;
    typedef struct { logic [63:0] addr; int cyc; } err_exp_t;
    typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] wstrb; } req_exp_t;

    wb_exp_t  wb_q[$];
    err_exp_t err_q[$];
    req_exp_t req_q[$];

    logic [7:0]  ref_mem[longint unsigned];
    logic [63:0] dc_mem[longint unsigned];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          resp_pending = 1'b0;
    int          resp_cnt = 0;
    logic [63:0] resp_addr = '0;
    int          resp_cyc = -1;
    int          lat_fixed = -1;
    int          stall_left = 0;
    bit          rand_ready = 1'b1;
    bit          force_resp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [63:0] dc_rd(input logic [63:0] a);
        return dc_mem.exists(a) ? dc_mem[a] : 64'h0;
    endfunction

    // kind: 0 = no memory access, 1 = load, 2 = store; nb = access bytes
    function automatic void decode(input logic [3:0] op, output int kind, output int nb, output bit sgn);
        kind = 1; nb = 0; sgn = 1'b0;
        case (op)
            4'd1:    begin nb = 1; sgn = 1'b1; end
            4'd2:    begin nb = 2; sgn = 1'b1; end
            4'd3:    begin nb = 4; sgn = 1'b1; end
            4'd4:    begin nb = 8; sgn = 1'b1; end
            4'd5:    nb = 1;
            4'd6:    nb = 2;
            4'd7:    nb = 4;
            4'd8:    begin kind = 2; nb = 1; end
            4'd9:    begin kind = 2; nb = 2; end
            4'd10:   begin kind = 2; nb = 4; end
            4'd11:   begin kind = 2; nb = 8; end
            default: kind = 0;
        endcase
    endfunction

    task automatic preload(input logic [63:0] a, input logic [63:0] v);
        dc_mem[a] = v;
        for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = v[8*i +: 8];
    endtask

    // Presents one op, waits for acceptance, then records what must follow.
    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [63:0] data,
                         input logic [63:0] addr, output int waited);
        int kind, nb, off, acc;
        bit sgn;
        logic [63:0] ea, v;
        wb_exp_t w;
        err_exp_t e;
        req_exp_t r;
        decode(op, kind, nb, sgn);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_data = data; in_addr = addr;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc;
        ea = (kind == 2) ? addr : data;
        if (kind == 0) begin
            if (rd != 5'd0) begin
                w.rd = rd; w.data = data; w.cyc = acc;
                wb_q.push_back(w);
            end
        end else if ((ea % 64'(nb)) != 64'd0) begin
            e.addr = ea; e.cyc = acc;
            err_q.push_back(e);
        end else begin
            off = int'(ea[2:0]);
            r.addr = ea & ~64'h7; r.we = (kind == 2); r.wstrb = '0; r.wdata = '0;
            if (kind == 2) begin
                for (int i = 0; i < nb; i++) begin
                    r.wstrb[off + i] = 1'b1;
                    r.wdata[8*(off + i) +: 8] = data[8*i +: 8];
                    ref_mem[ea + 64'(i)] = data[8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_rd(ea + 64'(i));
                if (sgn && v[8*nb - 1])
                    for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
                if (rd != 5'd0) begin
                    w.rd = rd; w.data = v; w.cyc = -1;
                    wb_q.push_back(w);
                end
            end
            req_q.push_back(r);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((wb_q.size() != 0 || err_q.size() != 0 || req_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_wb_q", 64'(wb_q.size()), 64'd0);
        check("drain_err_q", 64'(err_q.size()), 64'd0);
        check("drain_req_q", 64'(req_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_dc_req_valid"}, 64'(dc_req_valid), 64'd0);
        check({tag, "_dc_req_addr"}, dc_req_addr, 64'd0);
        check({tag, "_dc_req_we"}, 64'(dc_req_we), 64'd0);
        check({tag, "_dc_req_wdata"}, dc_req_wdata, 64'd0);
        check({tag, "_dc_req_wstrb"}, 64'(dc_req_wstrb), 64'd0);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        check({tag, "_wb_data"}, wb_data, 64'd0);
        check({tag, "_err_valid"}, 64'(err_valid), 64'd0);
        check({tag, "_err_addr"}, err_addr, 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor and cache request side: everything sampled on the falling edge.
    initial begin
        wb_exp_t  we_;
        err_exp_t ee;
        req_exp_t re;
        logic [63:0] cur;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                if (wb_q.size() == 0) check("wb_unexpected", 64'(wb_valid), 64'd0);
                else begin
                    we_ = wb_q.pop_front();
                    check("wb_rd", 64'(wb_rd), 64'(we_.rd));
                    check("wb_data", wb_data, we_.data);
                    check("wb_cycle", 64'(cyc), 64'((we_.cyc < 0) ? resp_cyc : we_.cyc));
                end
            end
            if (err_valid) begin
                if (err_q.size() == 0) check("err_unexpected", 64'(err_valid), 64'd0);
                else begin
                    ee = err_q.pop_front();
                    check("err_addr", err_addr, ee.addr);
                    check("err_cycle", 64'(cyc), 64'(ee.cyc));
                end
            end
            if (dc_req_valid) begin
                if (req_q.size() == 0) check("req_unexpected", 64'(dc_req_valid), 64'd0);
                else begin
                    re = req_q[0];
                    check("req_addr", dc_req_addr, re.addr);
                    check("req_we", 64'(dc_req_we), 64'(re.we));
                    check("req_wstrb", 64'(dc_req_wstrb), 64'(re.wstrb));
                    if (re.we) check("req_wdata", dc_req_wdata, re.wdata);
                    if (dc_req_ready) begin
                        void'(req_q.pop_front());
                        if (dc_req_we) begin
                            cur = dc_rd(dc_req_addr);
                            for (int b = 0; b < 8; b++)
                                if (dc_req_wstrb[b]) cur[8*b +: 8] = dc_req_wdata[8*b +: 8];
                            dc_mem[dc_req_addr] = cur;
                        end else begin
                            resp_pending = 1'b1;
                            resp_addr = dc_req_addr;
                            resp_cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                        end
                    end
                end
            end
        end
    end

    // Cache drive side: ready back-pressure and delayed load responses.
    initial begin
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
        forever begin
            @(posedge clk);
            #2;
            dc_resp_valid = 1'b0;
            dc_resp_data = {$urandom, $urandom};
            if (force_resp) begin
                dc_resp_valid = 1'b1;
                force_resp = 1'b0;
            end else if (resp_pending) begin
                if (resp_cnt == 0) begin
                    dc_resp_valid = 1'b1;
                    dc_resp_data = dc_rd(resp_addr);
                    resp_pending = 1'b0;
                    resp_cyc = cyc + 1;
                end else resp_cnt--;
            end
            if (stall_left > 0) begin
                dc_req_ready = 1'b0;
                stall_left--;
            end else dc_req_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1, n, kind, nb;
        bit sgn;
        logic [3:0] op;
        logic [4:0] rd;
        logic [63:0] a, d;

        in_valid = 1'b0; in_op = '0; in_rd = '0; in_data = '0; in_addr = '0;
        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back pass-through.
        rand_ready = 1'b0;
        issue(4'd0, 5'd5, 64'h1234, 64'hDEAD_0000_0000_0001, w0);
        issue(4'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, w1);
        check("pass_ready_first", 64'(w0), 64'd0);
        check("pass_ready_second", 64'(w1), 64'd0);
        drain();

        // Sign-extended byte load, fixed cache latency.
        lat_fixed = 1;
        preload(64'h1000, 64'h0000_0000_8000_0000);
        issue(4'd1, 5'd10, 64'h1003, 64'h5555, w0);
        drain();

        // Zero-extended halfword load.
        preload(64'h2000, 64'hBEEF_0000_0000_0000);
        issue(4'd6, 5'd11, 64'h2006, 64'h0, w0);
        drain();

        // Word store held off by three stalled cycles, then read back.
        stall_left = 4;
        issue(4'd10, 5'd12, 64'hAAAA_BBBB_CCCC_DDDD, 64'h3004, w0);
        drain();
        @(negedge clk);
        check("store_in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        issue(4'd3, 5'd13, 64'h3004, 64'h0, w0);
        drain();

        // Misaligned doubleword load.
        issue(4'd4, 5'd14, 64'h4004, 64'h0, w0);
        drain();

        // Reset while waiting for a load response.
        lat_fixed = 20;
        issue(4'd4, 5'd15, 64'h8000, 64'h0, w0);
        n = 0;
        while (!resp_pending && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_reached", 64'(resp_pending), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        resp_pending = 1'b0;
        wb_q.delete();
        req_q.delete();
        #1;
        check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        force_resp = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        issue(4'd0, 5'd7, 64'hCAFE, 64'h0, w0);
        drain();

        // Randomized mix over a small shared address window.
        lat_fixed = -1;
        rand_ready = 1'b1;
        for (int k = 0; k < 250; k++) begin
            op = 4'($urandom_range(0, 15));
            rd = 5'($urandom_range(0, 31));
            a = 64'h8000 + 64'($urandom_range(0, 63));
            d = {$urandom, $urandom};
            decode(op, kind, nb, sgn);
            if (kind != 0 && $urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
            if (kind == 0) issue(op, rd, d, {$urandom, $urandom}, w0);
            else if (kind == 1) issue(op, rd, a, {$urandom, $urandom}, w0);
            else issue(op, rd, d, a, w0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        @(negedge clk);
        check("final_in_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
